mine_placer: RTL and testbench
==============================

Name: mine_placer

Overview:
- Downstream consumer of the minesweeper random coordinate generator.
- Samples the generator's random_row/random_col stream and places exactly total_mines distinct mines on the board; duplicate coordinates are rejected.
- After placement, runs a sequential pass that computes the adjacent-mine count of every cell.
- Exposes a read port used by the display/game-logic stage.

Parameters:
- ROWS, 8, board rows; row coordinate width is clog2(ROWS).
- COLS, 8, board columns; column coordinate width is clog2(COLS).
- CNT_W, 4, width of each stored adjacency count (holds 0..8).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; begins a new board build when in IDLE or DONE.
- total_mines  in  4  requested mine count 0..15; sampled on the accepted start.
- random_row  in  3  row from the upstream random generator; valid every cycle.
- random_col  in  3  column from the upstream random generator; valid every cycle.
- rd_row  in  3  read-port row.
- rd_col  in  3  read-port column.
- rd_mine  out  1  1 if cell (rd_row, rd_col) holds a mine; combinational from the mine map.
- rd_count  out  CNT_W  adjacent-mine count of the read cell; combinational from the count array.
- placed  out  4  number of mines placed so far.
- busy  out  1  high in CLEAR, PLACE and COUNT.
- done  out  1  high in DONE; held until the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Mine map (ROWS*COLS bits), count array, placed, cell index and target register all clear to 0.
  - busy=0, done=0, rd_mine=0, rd_count=0.
- States: IDLE, CLEAR, PLACE, COUNT, DONE.
- IDLE / DONE: start=1 latches total_mines into target, then goes to CLEAR. Any start seen in CLEAR, PLACE or COUNT is ignored.
- CLEAR (1 cycle):
  - Zeroes the mine map, count array and placed.
  - Next state is PLACE if target != 0, otherwise COUNT.
- PLACE (one candidate per cycle, coordinates (random_row, random_col)):
  - If the cell is empty: set its mine bit and increment placed.
  - If the cell already holds a mine: drop the candidate; nothing changes.
  - On the cycle placed reaches target, go to COUNT.
  - No timeout: the upstream generator guarantees coverage.
- COUNT (exactly ROWS*COLS cycles):
  - Index idx runs 0..63 in row-major order, so row = idx/COLS and col = idx%COLS.
  - Each cycle, count[idx] <= number of mines among the up-to-8 in-board neighbours of that cell. Off-board neighbours count as 0: no wrap-around at edges.
  - The cell's own mine bit is excluded from its count.
  - After idx=63, go to DONE and reset idx to 0.
- Latency: an accepted start reaches done after 1 + (PLACE cycles, at least target) + 64 cycles. With target=0 this is exactly 65 cycles.
- The read port is live in every state. Contents are meaningful only while done=1.
- Reset asserted mid-operation aborts immediately and clears everything. After release, the block sits in IDLE.

Optional Feature:
- Macro MINE_PLACER_SAFE_START_EN.
- When defined:
  - Adds inputs safe_row[2:0] and safe_col[2:0], sampled on the accepted start.
  - In PLACE, any candidate inside the 3x3 block centred on the safe cell (clipped to the board) is rejected like a duplicate.
  - total_mines is clamped to min(total_mines, 64 - safe-zone size).
- When undefined: the ports are absent and every cell is eligible.

Decomposition:
- Package busca_minas_pkg:
  - ROWS, COLS, ROW_W, COL_W, CELLS constants.
  - State enum type.
  - cell_idx_t and adj_cnt_t typedefs.
- Sub-module neighbour_counter: purely combinational.
  - Inputs: mine map, row, col. Output: CNT_W count.
  - Applies edge masking.
  - Instantiated once for the COUNT pass.

Test Plan:
1. Async reset mid-PLACE (rst=0 between clock edges) -> state IDLE, placed=0, busy=0, done=0 and rd_mine=0 for every cell, with no clock edge needed.
2. total_mines=5; force random stream (0,0),(0,0),(1,1),(7,7),(1,1),(3,4),(0,7) -> mines at exactly (0,0),(1,1),(7,7),(3,4),(0,7); placed=5; duplicates dropped; count(0,1)=2, count(7,6)=1, count(4,4)=1.
3. total_mines=0, start -> done rises exactly 65 cycles after the start edge; all rd_mine=0 and all rd_count=0.
4. Corner and edge counts: mines at (0,1),(1,0),(1,1) -> count(0,0)=3; mines at (7,6),(6,7) -> count(7,7)=2; verify no wrap to (0,*).
5. start pulsed during COUNT -> ignored; done asserts at the originally expected cycle and placed is unchanged.
6. MINE_PLACER_SAFE_START_EN defined, safe=(0,0), total_mines=15, random stream drives (0,0),(0,1),(1,1) -> all three rejected; final map has 15 mines, none in rows 0-1 × cols 0-1.

Source files
------------

// File: rtl/busca_minas_pkg.sv
// Shared board geometry, FSM state encoding and cell/count types for the mine placer.
package busca_minas_pkg;

   localparam int unsigned ROWS   = 8;
   localparam int unsigned COLS   = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ROW_W  = $clog2(ROWS);
   localparam int unsigned COL_W  = $clog2(COLS);
   localparam int unsigned CELLS  = ROWS * COLS;
   localparam int unsigned CELL_W = $clog2(CELLS);
   localparam int unsigned MINE_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_PLACE = 3'd2,
      ST_COUNT = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   typedef logic [CELL_W-1:0] cell_idx_t;
   typedef logic [CNT_W-1:0]  adj_cnt_t;

   // Row-major flat index; COLS is a power of two so this is a plain concatenation.
   function automatic cell_idx_t cell_idx(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/mine_placer_neighbour_counter.sv
// Combinational adjacent-mine counter for one cell; off-board neighbours are masked, no wrap.
module neighbour_counter
   import busca_minas_pkg::*;
(
   input  logic [CELLS-1:0] i_map,
   input  logic [ROW_W-1:0] i_row,
   input  logic [COL_W-1:0] i_col,
   output adj_cnt_t         o_count_c
);

   logic [8:0] w_hit;

   // Offsets are added one bit wider so that -1 at row/col 0 lands above the board and is masked.
   for (genvar k = 0; k < 9; k++) begin : g_nbr
      localparam int DR = (k / 3) - 1;
      localparam int DC = (k % 3) - 1;
      logic [ROW_W:0] w_r;
      logic [COL_W:0] w_c;
      assign w_r = {1'b0, i_row} + (ROW_W+1)'(DR);
      assign w_c = {1'b0, i_col} + (COL_W+1)'(DC);
      if (k == 4) begin : g_self
         assign w_hit[k] = 1'b0;
      end else begin : g_other
         assign w_hit[k] = (w_r < (ROW_W+1)'(ROWS)) && (w_c < (COL_W+1)'(COLS)) &&
                           i_map[cell_idx(w_r[ROW_W-1:0], w_c[COL_W-1:0])];
      end
   end

   always_comb begin
      o_count_c = '0;
      for (int k = 0; k < 9; k++) begin
         o_count_c = o_count_c + CNT_W'(w_hit[k]);
      end
   end

endmodule

// File: rtl/mine_placer.sv
// Places total_mines distinct mines from a random coordinate stream, then computes per-cell adjacency counts.
// Optional safe-start zone enabled by defining MINE_PLACER_SAFE_START_EN.
module mine_placer
   import busca_minas_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [MINE_W-1:0] total_mines,
   input  logic [ROW_W-1:0]  random_row,
   input  logic [COL_W-1:0]  random_col,
   input  logic [ROW_W-1:0]  rd_row,
   input  logic [COL_W-1:0]  rd_col,
`ifdef MINE_PLACER_SAFE_START_EN
   input  logic [ROW_W-1:0]  safe_row,
   input  logic [COL_W-1:0]  safe_col,
`endif
   output logic              rd_mine,
   output adj_cnt_t          rd_count,
   output logic [MINE_W-1:0] placed,
   output logic              busy,
   output logic              done
);

   localparam int unsigned LIM_W = CELL_W + 1;

   state_e            r_state;
   logic [CELLS-1:0]  r_map;
   adj_cnt_t          r_cnt [CELLS];
   logic [MINE_W-1:0] r_placed;
   logic [MINE_W-1:0] r_target;
   cell_idx_t         r_idx;
   logic              r_busy;
   logic              r_done;

   cell_idx_t         w_cand;
   cell_idx_t         w_rd;
   logic              w_reject;
   logic [MINE_W-1:0] w_target;
   logic [MINE_W-1:0] w_placed_nxt;
   adj_cnt_t          w_nbr_cnt;

   assign w_cand       = cell_idx(random_row, random_col);
   assign w_rd         = cell_idx(rd_row, rd_col);
   assign w_placed_nxt = r_placed + MINE_W'(1);

`ifdef MINE_PLACER_SAFE_START_EN
   logic [ROW_W-1:0]  r_safe_row;
   logic [COL_W-1:0]  r_safe_col;
   logic              w_row_near;
   logic              w_col_near;
   logic [1:0]        w_zone_rows;
   logic [1:0]        w_zone_cols;
   logic [3:0]        w_zone_size;
   logic [LIM_W-1:0]  w_limit;

   // Candidate lies within one row and one column of the latched safe cell.
   assign w_row_near = ({1'b0, random_row} + (ROW_W+1)'(1) >= {1'b0, r_safe_row}) &&
                       ({1'b0, random_row} <= {1'b0, r_safe_row} + (ROW_W+1)'(1));
   assign w_col_near = ({1'b0, random_col} + (COL_W+1)'(1) >= {1'b0, r_safe_col}) &&
                       ({1'b0, random_col} <= {1'b0, r_safe_col} + (COL_W+1)'(1));
   assign w_reject   = r_map[w_cand] || (w_row_near && w_col_near);

   // Safe-zone footprint shrinks at board edges; the remaining cells cap the mine count.
   assign w_zone_rows = 2'd3 - 2'(safe_row == '0) - 2'(safe_row == ROW_W'(ROWS-1));
   assign w_zone_cols = 2'd3 - 2'(safe_col == '0) - 2'(safe_col == COL_W'(COLS-1));
   assign w_zone_size = 4'(w_zone_rows) * 4'(w_zone_cols);
   assign w_limit     = LIM_W'(CELLS) - LIM_W'(w_zone_size);
   assign w_target    = (LIM_W'(total_mines) > w_limit) ? MINE_W'(w_limit) : total_mines;
`else
   assign w_reject = r_map[w_cand];
   assign w_target = total_mines;
`endif

   neighbour_counter u_nbr (
      .i_map     (r_map),
      .i_row     (r_idx[CELL_W-1 -: ROW_W]),
      .i_col     (r_idx[COL_W-1:0]),
      .o_count_c (w_nbr_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_map    <= '0;
         r_cnt    <= '{default: '0};
         r_placed <= '0;
         r_target <= '0;
         r_idx    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef MINE_PLACER_SAFE_START_EN
         r_safe_row <= '0;
         r_safe_col <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_target <= w_target;
`ifdef MINE_PLACER_SAFE_START_EN
                  r_safe_row <= safe_row;
                  r_safe_col <= safe_col;
`endif
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_state  <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               r_map    <= '0;
               r_cnt    <= '{default: '0};
               r_placed <= '0;
               r_idx    <= '0;
               r_state  <= (r_target != '0) ? ST_PLACE : ST_COUNT;
            end
            ST_PLACE: begin
               // Duplicates (and safe-zone hits) are dropped; the generator keeps supplying candidates.
               if (!w_reject) begin
                  r_map[w_cand] <= 1'b1;
                  r_placed      <= w_placed_nxt;
                  if (w_placed_nxt == r_target) begin
                     r_state <= ST_COUNT;
                  end
               end
            end
            ST_COUNT: begin
               r_cnt[r_idx] <= w_nbr_cnt;
               if (r_idx == cell_idx_t'(CELLS-1)) begin
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_idx <= r_idx + CELL_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign rd_mine  = r_map[w_rd];
   assign rd_count = r_cnt[w_rd];
   assign placed   = r_placed;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_mine_placer.sv
// Directed self-checking bench for mine_placer: table-driven read-port vectors plus multi-cycle sequences.
module tb_mine_placer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] total_mines = '0;
   logic [2:0] random_row = '0;
   logic [2:0] random_col = '0;
   logic [2:0] rd_row = '0;
   logic [2:0] rd_col = '0;
   logic       rd_mine;
   logic [3:0] rd_count;
   logic [3:0] placed;
   logic       busy;
   logic       done;
`ifdef MINE_PLACER_SAFE_START_EN
   logic [2:0] safe_row = 3'd7;
   logic [2:0] safe_col = 3'd0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int r;
      int c;
      int mine;
      int cnt;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   mine_placer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .total_mines (total_mines),
      .random_row  (random_row),
      .random_col  (random_col),
      .rd_row      (rd_row),
      .rd_col      (rd_col),
`ifdef MINE_PLACER_SAFE_START_EN
      .safe_row    (safe_row),
      .safe_col    (safe_col),
`endif
      .rd_mine     (rd_mine),
      .rd_count    (rd_count),
      .placed      (placed),
      .busy        (busy),
      .done        (done)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start, then step past the CLEAR edge so the next edge samples the first candidate.
   task automatic start_build(input int total);
      total_mines = 4'(total);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic feed(input int r, input int c);
      random_row = 3'(r);
      random_col = 3'(c);
      tick();
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      while (!done && cyc < 300) begin
         tick();
         cyc++;
      end
      check({tag, "_done_reached"}, int'(done), 1);
   endtask

   task automatic sweep(input int r0, input int r1, input int c0, input int c1,
                        output int mines, output int cnt_sum);
      mines = 0;
      cnt_sum = 0;
      for (int r = r0; r <= r1; r++) begin
         for (int c = c0; c <= c1; c++) begin
            rd_row = 3'(r);
            rd_col = 3'(c);
            #1;
            mines   += int'(rd_mine);
            cnt_sum += int'(rd_count);
         end
      end
   endtask

   task automatic run_vectors(input string tag);
      foreach (vq[i]) begin
         rd_row = 3'(vq[i].r);
         rd_col = 3'(vq[i].c);
         #1;
         check($sformatf("%s_mine(%0d,%0d)", tag, vq[i].r, vq[i].c), int'(rd_mine), vq[i].mine);
         check($sformatf("%s_cnt(%0d,%0d)", tag, vq[i].r, vq[i].c), int'(rd_count), vq[i].cnt);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int cyc;
      int mines;
      int csum;

      // Reset state
      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_placed", int'(placed), 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Async reset mid-PLACE
      start_build(5);
      feed(1, 2);
      feed(3, 3);
      check("t1_placed_before", int'(placed), 2);
      check("t1_busy_before", int'(busy), 1);
      #2;
      rst = 1'b0;
      #1;
      check("t1_placed_async", int'(placed), 0);
      check("t1_busy_async", int'(busy), 0);
      check("t1_done_async", int'(done), 0);
      sweep(0, 7, 0, 7, mines, csum);
      check("t1_mines_cleared", mines, 0);
      check("t1_counts_cleared", csum, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      check("t1_idle_busy", int'(busy), 0);
      check("t1_idle_done", int'(done), 0);

      // Five mines with duplicates in the stream
      start_build(5);
      feed(0, 0);
      feed(0, 0);
      feed(1, 1);
      feed(7, 7);
      feed(1, 1);
      feed(3, 4);
      feed(0, 7);
      wait_done("t2");
      check("t2_placed", int'(placed), 5);
      check("t2_busy", int'(busy), 0);
      sweep(0, 7, 0, 7, mines, csum);
      check("t2_total_mines", mines, 5);
      vq.delete();
      vq.push_back('{0, 0, 1, 1});
      vq.push_back('{0, 1, 0, 2});
      vq.push_back('{7, 6, 0, 1});
      vq.push_back('{4, 4, 0, 1});
      vq.push_back('{1, 1, 1, 1});
      vq.push_back('{3, 4, 1, 0});
      vq.push_back('{0, 7, 1, 0});
      vq.push_back('{2, 2, 0, 1});
      vq.push_back('{6, 6, 0, 1});
      run_vectors("t2");

      // Corner and edge counts, no wrap-around
      start_build(5);
      feed(0, 1);
      feed(1, 0);
      feed(1, 1);
      feed(7, 6);
      feed(6, 7);
      wait_done("t4");
      check("t4_placed", int'(placed), 5);
      vq.delete();
      vq.push_back('{0, 0, 0, 3});
      vq.push_back('{7, 7, 0, 2});
      vq.push_back('{0, 7, 0, 0});
      vq.push_back('{7, 0, 0, 0});
      vq.push_back('{1, 1, 1, 2});
      vq.push_back('{0, 1, 1, 2});
      vq.push_back('{6, 6, 0, 2});
      vq.push_back('{0, 6, 0, 0});
      run_vectors("t4");

      // Zero mines: done exactly 65 cycles after the start edge
      total_mines = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      check("t3_done_dropped", int'(done), 0);
      check("t3_busy_raised", int'(busy), 1);
      while (!done && cyc < 300) begin
         tick();
         cyc++;
      end
      check("t3_latency", cyc, 65);
      check("t3_placed", int'(placed), 0);
      sweep(0, 7, 0, 7, mines, csum);
      check("t3_no_mines", mines, 0);
      check("t3_no_counts", csum, 0);

      // Start during COUNT is ignored
      random_row = 3'd2;
      random_col = 3'd2;
      total_mines = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      tick();
      cyc++;
      tick();
      cyc++;
      random_row = 3'd5;
      random_col = 3'd5;
      tick();
      cyc++;
      while (!done && cyc < 300) begin
         start = (cyc == 20) ? 1'b1 : 1'b0;
         total_mines = (cyc == 20) ? 4'd9 : 4'd2;
         tick();
         cyc++;
      end
      start = 1'b0;
      check("t5_latency", cyc, 67);
      check("t5_placed", int'(placed), 2);
      check("t5_busy", int'(busy), 0);
      vq.delete();
      vq.push_back('{2, 2, 1, 0});
      vq.push_back('{5, 5, 1, 0});
      vq.push_back('{3, 3, 0, 1});
      vq.push_back('{4, 4, 0, 1});
      run_vectors("t5");
      tick();
      tick();
      check("t5_done_held", int'(done), 1);

`ifdef MINE_PLACER_SAFE_START_EN
      // Safe zone around (0,0) rejects nearby candidates
      safe_row = 3'd0;
      safe_col = 3'd0;
      start_build(15);
      feed(0, 0);
      feed(0, 1);
      feed(1, 1);
      check("t6_rejected", int'(placed), 0);
      for (int i = 0; i < 15; i++) begin
         feed(2 + i / 8, i % 8);
      end
      wait_done("t6");
      check("t6_placed", int'(placed), 15);
      sweep(0, 7, 0, 7, mines, csum);
      check("t6_total_mines", mines, 15);
      sweep(0, 1, 0, 1, mines, csum);
      check("t6_zone_empty", mines, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
